// File: rtl/axil_master_arbiter_if.sv
// Bundles the two client request ports and the shared AXI-Lite master
// request/response ports. The arbiter uses the master modport.
interface axil_master_arbiter_if #(
    parameter int REG_WIDTH = 32
);
    logic                 REQ0_VALID;
    logic                 REQ0_WRITE;
    logic [REG_WIDTH-1:0] REQ0_ADDR;
    logic [REG_WIDTH-1:0] REQ0_WDATA;
    logic                 REQ0_READY;
    logic                 REQ0_DONE;
    logic [REG_WIDTH-1:0] REQ0_RDATA;
    logic [1:0]           REQ0_RESP;

    logic                 REQ1_VALID;
    logic                 REQ1_WRITE;
    logic [REG_WIDTH-1:0] REQ1_ADDR;
    logic [REG_WIDTH-1:0] REQ1_WDATA;
    logic                 REQ1_READY;
    logic                 REQ1_DONE;
    logic [REG_WIDTH-1:0] REQ1_RDATA;
    logic [1:0]           REQ1_RESP;

    logic                 M_RRQST;
    logic [REG_WIDTH-1:0] M_RADDR;
    logic                 M_RACK;
    logic                 M_RVALID;
    logic [REG_WIDTH-1:0] M_RDATA;
    logic                 M_WRQST;
    logic [REG_WIDTH-1:0] M_WADDR;
    logic [REG_WIDTH-1:0] M_WDATA;
    logic                 M_WACK;
    logic                 M_BVALID;
    logic                 M_WRESULT;

    modport master (
        input  REQ0_VALID, REQ0_WRITE, REQ0_ADDR, REQ0_WDATA,
        output REQ0_READY, REQ0_DONE, REQ0_RDATA, REQ0_RESP,
        input  REQ1_VALID, REQ1_WRITE, REQ1_ADDR, REQ1_WDATA,
        output REQ1_READY, REQ1_DONE, REQ1_RDATA, REQ1_RESP,
        output M_RRQST, M_RADDR,
        input  M_RACK, M_RVALID, M_RDATA,
        output M_WRQST, M_WADDR, M_WDATA,
        input  M_WACK, M_BVALID, M_WRESULT
    );

    modport slave (
        output REQ0_VALID, REQ0_WRITE, REQ0_ADDR, REQ0_WDATA,
        input  REQ0_READY, REQ0_DONE, REQ0_RDATA, REQ0_RESP,
        output REQ1_VALID, REQ1_WRITE, REQ1_ADDR, REQ1_WDATA,
        input  REQ1_READY, REQ1_DONE, REQ1_RDATA, REQ1_RESP,
        input  M_RRQST, M_RADDR,
        output M_RACK, M_RVALID, M_RDATA,
        input  M_WRQST, M_WADDR, M_WDATA,
        output M_WACK, M_BVALID, M_WRESULT
    );
endinterface

// File: rtl/axil_master_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite master between two clients, one
// transaction in flight, with a watchdog that forces an SLVERR completion.
module axil_master_arbiter #(
    parameter int REG_WIDTH = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    axil_master_arbiter_if.master bus,
    output logic [2:0]            o_state
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_R = 3'd1,
        WAIT_R  = 3'd2,
        ISSUE_W = 3'd3,
        WAIT_W  = 3'd4,
        RESP    = 3'd5
    } state_t;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    state_t               r_state;
    logic                 r_last;
    logic                 r_gid;
    logic [REG_WIDTH-1:0] r_addr;
    logic [REG_WIDTH-1:0] r_wdata;
    logic [TW-1:0]        r_timer;
    logic [REG_WIDTH-1:0] r_rdata0, r_rdata1;
    logic [1:0]           r_resp0, r_resp1;

    state_t               w_state_nxt;
    logic                 w_grant_vld;
    logic                 w_grant_id;
    logic                 w_sel_write;
    logic [REG_WIDTH-1:0] w_sel_addr;
    logic [REG_WIDTH-1:0] w_sel_wdata;
    logic                 w_timeout;
    logic                 w_cpl;
    logic [REG_WIDTH-1:0] w_cpl_rdata;
    logic [1:0]           w_cpl_resp;

    // Handshake: a request is accepted at the rising edge where REQx_VALID
    // and REQx_READY are both high; READY is high only in IDLE for the
    // single granted client, and VALID may drop without being accepted.
    assign w_grant_vld = bus.REQ0_VALID | bus.REQ1_VALID;
    assign w_grant_id  = (bus.REQ0_VALID & bus.REQ1_VALID) ? ~r_last : bus.REQ1_VALID;
    assign w_sel_write = w_grant_id ? bus.REQ1_WRITE : bus.REQ0_WRITE;
    assign w_sel_addr  = w_grant_id ? bus.REQ1_ADDR  : bus.REQ0_ADDR;
    assign w_sel_wdata = w_grant_id ? bus.REQ1_WDATA : bus.REQ0_WDATA;
    assign w_timeout   = (TIMEOUT != 0) && (r_timer == TIMER_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_cpl       = 1'b0;
        w_cpl_rdata = '0;
        w_cpl_resp  = 2'b00;
        case (r_state)
            IDLE: begin
                if (w_grant_vld) w_state_nxt = w_sel_write ? ISSUE_W : ISSUE_R;
            end
            ISSUE_R, WAIT_R: begin
                // A real completion on the watchdog edge takes priority.
                if (bus.M_RVALID && (r_state == WAIT_R || bus.M_RACK)) begin
                    w_cpl       = 1'b1;
                    w_cpl_rdata = bus.M_RDATA;
                end else if (w_timeout) begin
                    w_cpl      = 1'b1;
                    w_cpl_resp = 2'b10;
                end else if (r_state == ISSUE_R && bus.M_RACK) begin
                    w_state_nxt = WAIT_R;
                end
            end
            ISSUE_W, WAIT_W: begin
                if (bus.M_BVALID && (r_state == WAIT_W || bus.M_WACK)) begin
                    w_cpl      = 1'b1;
                    w_cpl_resp = bus.M_WRESULT ? 2'b00 : 2'b10;
                end else if (w_timeout) begin
                    w_cpl      = 1'b1;
                    w_cpl_resp = 2'b10;
                end else if (r_state == ISSUE_W && bus.M_WACK) begin
                    w_state_nxt = WAIT_W;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (w_cpl) w_state_nxt = RESP;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state  <= IDLE;
            r_last   <= 1'b1;
            r_gid    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_timer  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_resp0  <= 2'b00;
            r_resp1  <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_grant_vld) begin
                r_gid   <= w_grant_id;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_timer <= '0;
            end else if (r_state != IDLE && r_state != RESP) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_cpl && !r_gid) begin
                r_rdata0 <= w_cpl_rdata;
                r_resp0  <= w_cpl_resp;
            end
            if (w_cpl && r_gid) begin
                r_rdata1 <= w_cpl_rdata;
                r_resp1  <= w_cpl_resp;
            end
            if (r_state == RESP) r_last <= r_gid;
        end
    end

    // READY is gated by reset so every output reads 0 while ARESETN is low.
    assign bus.REQ0_READY = ARESETN && (r_state == IDLE) && w_grant_vld && !w_grant_id;
    assign bus.REQ1_READY = ARESETN && (r_state == IDLE) && w_grant_vld &&  w_grant_id;
    assign bus.REQ0_DONE  = (r_state == RESP) && !r_gid;
    assign bus.REQ1_DONE  = (r_state == RESP) &&  r_gid;
    assign bus.REQ0_RDATA = r_rdata0;
    assign bus.REQ1_RDATA = r_rdata1;
    assign bus.REQ0_RESP  = r_resp0;
    assign bus.REQ1_RESP  = r_resp1;

    assign bus.M_RRQST = (r_state == ISSUE_R);
    assign bus.M_RADDR = (r_state == ISSUE_R) ? r_addr : '0;
    assign bus.M_WRQST = (r_state == ISSUE_W);
    assign bus.M_WADDR = (r_state == ISSUE_W) ? r_addr : '0;
    assign bus.M_WDATA = (r_state == ISSUE_W) ? r_wdata : '0;

    assign o_state = r_state;
endmodule

// File: tb/tb_axil_master_arbiter.sv
// Directed bench for axil_master_arbiter: a table of single-client
// transactions plus hand-written contention, timeout and reset sequences.
module tb_axil_master_arbiter;
    localparam int W = 32;

    logic       ACLK = 1'b0;
    logic       ARESETN = 1'b0;
    logic [2:0] dbg_state;

    always #5 ACLK = ~ACLK;

    axil_master_arbiter_if #(.REG_WIDTH(W)) bus ();

    axil_master_arbiter #(.REG_WIDTH(W), .TIMEOUT(16)) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .bus     (bus),
        .o_state (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic         client;
        logic         write;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        int           ack_d;
        int           resp_d;
        logic         same;
        logic [W-1:0] mdata;
        logic         wres;
        logic [W-1:0] exp_rdata;
        logic [1:0]   exp_resp;
        int           exp_done_k;
        int           exp_rqst;
    } vec_t;

    vec_t vecs[8];

    // Master model: ack/response timing counted from the first request cycle.
    int           cfg_ack_d = 0;
    int           cfg_resp_d = 1;
    logic         cfg_same = 1'b0;
    logic         cfg_late = 1'b0;
    logic [W-1:0] cfg_mdata = '0;
    logic         cfg_wres = 1'b1;

    initial begin
        int   rk;
        logic prev_rqst;
        logic rqst;
        logic ack;
        logic vld;
        int   vk;
        rk = 1000;
        prev_rqst = 1'b0;
        bus.M_RACK = 1'b0; bus.M_WACK = 1'b0;
        bus.M_RVALID = 1'b0; bus.M_BVALID = 1'b0;
        bus.M_RDATA = '0; bus.M_WRESULT = 1'b0;
        forever begin
            @(negedge ACLK);
            rqst = bus.M_RRQST | bus.M_WRQST;
            if (rqst && !prev_rqst) rk = 0;
            else if (rk < 1000000) rk++;
            prev_rqst = rqst;
            vk  = cfg_same ? cfg_ack_d : cfg_ack_d + cfg_resp_d;
            ack = (rk == cfg_ack_d);
            vld = (rk == vk) && (cfg_ack_d >= 0);
            bus.M_RACK    = ack;
            bus.M_WACK    = ack;
            bus.M_RVALID  = vld | cfg_late;
            bus.M_BVALID  = vld | cfg_late;
            bus.M_RDATA   = cfg_mdata;
            bus.M_WRESULT = cfg_wres;
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic ready_of(input logic c);
        return c ? bus.REQ1_READY : bus.REQ0_READY;
    endfunction

    function automatic logic done_of(input logic c);
        return c ? bus.REQ1_DONE : bus.REQ0_DONE;
    endfunction

    function automatic logic [W-1:0] rdata_of(input logic c);
        return c ? bus.REQ1_RDATA : bus.REQ0_RDATA;
    endfunction

    function automatic logic [1:0] resp_of(input logic c);
        return c ? bus.REQ1_RESP : bus.REQ0_RESP;
    endfunction

    task automatic set_req(input logic c, input logic v, input logic wr,
                           input logic [W-1:0] a, input logic [W-1:0] d);
        if (c) begin
            bus.REQ1_VALID = v; bus.REQ1_WRITE = wr; bus.REQ1_ADDR = a; bus.REQ1_WDATA = d;
        end else begin
            bus.REQ0_VALID = v; bus.REQ0_WRITE = wr; bus.REQ0_ADDR = a; bus.REQ0_WDATA = d;
        end
    endtask

    task automatic set_master(input int ack_d, input int resp_d, input logic same,
                              input logic [W-1:0] mdata, input logic wres);
        cfg_ack_d = ack_d; cfg_resp_d = resp_d; cfg_same = same;
        cfg_mdata = mdata; cfg_wres = wres;
    endtask

    // Waits on negedges for client c's DONE; cyc is the cycle index or -1.
    task automatic wait_done(input logic c, input int bound, output int cyc, output int rq);
        cyc = -1;
        rq  = 0;
        for (int k = 0; k < bound; k++) begin
            @(negedge ACLK);
            if (bus.M_RRQST || bus.M_WRQST) rq++;
            if (done_of(c)) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic wait_ready(input logic c, input int bound, output logic got);
        got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge ACLK);
            if (ready_of(c)) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready0"}, bus.REQ0_READY, 0);
        chk({tag, "_ready1"}, bus.REQ1_READY, 0);
        chk({tag, "_done0"},  bus.REQ0_DONE, 0);
        chk({tag, "_done1"},  bus.REQ1_DONE, 0);
        chk({tag, "_rdata0"}, bus.REQ0_RDATA, 0);
        chk({tag, "_rdata1"}, bus.REQ1_RDATA, 0);
        chk({tag, "_resp0"},  bus.REQ0_RESP, 0);
        chk({tag, "_resp1"},  bus.REQ1_RESP, 0);
        chk({tag, "_rrqst"},  bus.M_RRQST, 0);
        chk({tag, "_raddr"},  bus.M_RADDR, 0);
        chk({tag, "_wrqst"},  bus.M_WRQST, 0);
        chk({tag, "_waddr"},  bus.M_WADDR, 0);
        chk({tag, "_wdata"},  bus.M_WDATA, 0);
        chk({tag, "_state"},  dbg_state, 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic got;
        logic r;
        int   rq;
        int   dk;
        int   other;
        string p;
        p = $sformatf("v%0d", idx);
        set_master(v.ack_d, v.resp_d, v.same, v.mdata, v.wres);
        @(posedge ACLK); #1;
        set_req(v.client, 1'b1, v.write, v.addr, v.wdata);
        wait_ready(v.client, 8, got);
        chk({p, "_ready"}, got, 1);
        chk({p, "_ready_other"}, ready_of(!v.client), 0);
        @(posedge ACLK); #1;
        set_req(v.client, 1'b0, 1'b0, '0, '0);
        rq = 0; dk = -1; other = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge ACLK);
            r = v.write ? bus.M_WRQST : bus.M_RRQST;
            if (r) rq++;
            if (done_of(!v.client)) other++;
            if (k == 0) begin
                chk({p, "_first_rqst"}, r, 1);
                chk({p, "_addr"}, v.write ? bus.M_WADDR : bus.M_RADDR, v.addr);
                if (v.write) chk({p, "_wdata"}, bus.M_WDATA, v.wdata);
            end
            if (done_of(v.client)) begin
                dk = k;
                chk({p, "_rdata"}, rdata_of(v.client), v.exp_rdata);
                chk({p, "_resp"}, resp_of(v.client), v.exp_resp);
                break;
            end
        end
        chk({p, "_done_cycle"}, dk, v.exp_done_k);
        chk({p, "_rqst_cycles"}, rq, v.exp_rqst);
        chk({p, "_other_done"}, other, 0);
        @(negedge ACLK);
        chk({p, "_done_pulse"}, done_of(v.client), 0);
        chk({p, "_rdata_hold"}, rdata_of(v.client), v.exp_rdata);
        chk({p, "_resp_hold"}, resp_of(v.client), v.exp_resp);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic got;
        int   cyc;
        int   rq;
        int   late_dones;
        logic g;

        vecs[0] = '{client:1'b0, write:1'b0, addr:32'd15,    wdata:32'h0,    ack_d:1,  resp_d:2,  same:1'b0,
                    mdata:32'h2564,     wres:1'b1, exp_rdata:32'h2564,     exp_resp:2'b00, exp_done_k:4,  exp_rqst:2};
        vecs[1] = '{client:1'b1, write:1'b1, addr:32'd10,    wdata:32'hABC,  ack_d:0,  resp_d:1,  same:1'b0,
                    mdata:32'h1111,     wres:1'b1, exp_rdata:32'h0,        exp_resp:2'b00, exp_done_k:2,  exp_rqst:1};
        vecs[2] = '{client:1'b0, write:1'b1, addr:32'h20,    wdata:32'h55,   ack_d:1,  resp_d:1,  same:1'b0,
                    mdata:32'h2222,     wres:1'b0, exp_rdata:32'h0,        exp_resp:2'b10, exp_done_k:3,  exp_rqst:2};
        vecs[3] = '{client:1'b1, write:1'b0, addr:32'h44,    wdata:32'h0,    ack_d:2,  resp_d:0,  same:1'b1,
                    mdata:32'hDEADBEEF, wres:1'b1, exp_rdata:32'hDEADBEEF, exp_resp:2'b00, exp_done_k:3,  exp_rqst:3};
        vecs[4] = '{client:1'b0, write:1'b1, addr:32'h80,    wdata:32'h1234, ack_d:0,  resp_d:0,  same:1'b1,
                    mdata:32'h3333,     wres:1'b1, exp_rdata:32'h0,        exp_resp:2'b00, exp_done_k:1,  exp_rqst:1};
        vecs[5] = '{client:1'b1, write:1'b0, addr:32'h100,   wdata:32'h0,    ack_d:0,  resp_d:15, same:1'b0,
                    mdata:32'hCAFE0001, wres:1'b1, exp_rdata:32'hCAFE0001, exp_resp:2'b00, exp_done_k:16, exp_rqst:1};
        vecs[6] = '{client:1'b0, write:1'b1, addr:32'h200,   wdata:32'h77,   ack_d:14, resp_d:1,  same:1'b0,
                    mdata:32'h4444,     wres:1'b1, exp_rdata:32'h0,        exp_resp:2'b00, exp_done_k:16, exp_rqst:15};
        vecs[7] = '{client:1'b1, write:1'b0, addr:32'h204,   wdata:32'h0,    ack_d:3,  resp_d:20, same:1'b0,
                    mdata:32'h5555,     wres:1'b1, exp_rdata:32'h0,        exp_resp:2'b10, exp_done_k:16, exp_rqst:4};

        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        ARESETN = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk_all_zero("reset");
        ARESETN = 1'b1;

        // Simultaneous requests straight after reset: client 0 goes first.
        set_master(0, 1, 1'b0, 32'h4444, 1'b1);
        @(posedge ACLK); #1;
        set_req(1'b0, 1'b1, 1'b1, 32'd10, 32'h2564);
        set_req(1'b1, 1'b1, 1'b0, 32'd4, 32'h0);
        @(negedge ACLK);
        chk("cont_ready0", bus.REQ0_READY, 1);
        chk("cont_ready1", bus.REQ1_READY, 0);
        @(posedge ACLK); #1;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        wait_done(1'b0, 20, cyc, rq);
        chk("cont_done0_seen", (cyc >= 0), 1);
        chk("cont_resp0", bus.REQ0_RESP, 2'b00);
        chk("cont_rdata0", bus.REQ0_RDATA, 0);
        wait_ready(1'b1, 10, got);
        chk("cont_ready1_second", got, 1);
        @(posedge ACLK); #1;
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        wait_done(1'b1, 20, cyc, rq);
        chk("cont_done1_seen", (cyc >= 0), 1);
        chk("cont_rdata1", bus.REQ1_RDATA, 32'h4444);
        chk("cont_resp1", bus.REQ1_RESP, 2'b00);

        // Both clients held valid: grants alternate starting with client 0.
        exp_q = '{0, 1, 0, 1};
        @(posedge ACLK); #1;
        set_req(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 32'h50, 32'h0);
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) begin
            @(negedge ACLK);
            if (bus.REQ0_READY || bus.REQ1_READY) begin
                chk("alt_one_ready", bus.REQ0_READY & bus.REQ1_READY, 0);
                g = bus.REQ1_READY;
                chk("alt_grant", g, exp_q.pop_front());
            end
        end
        chk("alt_grants_left", exp_q.size(), 0);
        @(posedge ACLK); #1;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (6) @(posedge ACLK);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Master never acks: watchdog ends it after 16 request cycles.
        set_master(-1, 1, 1'b0, 32'h6666, 1'b1);
        @(posedge ACLK); #1;
        set_req(1'b0, 1'b1, 1'b0, 32'h300, 32'h0);
        wait_ready(1'b0, 8, got);
        chk("to_ready", got, 1);
        @(posedge ACLK); #1;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        wait_done(1'b0, 40, cyc, rq);
        chk("to_done_cycle", cyc, 16);
        chk("to_rqst_cycles", rq, 16);
        chk("to_resp", bus.REQ0_RESP, 2'b10);
        chk("to_rdata", bus.REQ0_RDATA, 0);
        cfg_late = 1'b1;
        late_dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge ACLK);
            if (i == 3) cfg_late = 1'b0;
            if (bus.REQ0_DONE || bus.REQ1_DONE) late_dones++;
        end
        chk("to_late_no_done", late_dones, 0);
        chk("to_idle_after_late", dbg_state, 0);

        // Reset while waiting for a write response: nothing completes.
        set_master(0, 30, 1'b0, 32'h9999, 1'b1);
        @(posedge ACLK); #1;
        set_req(1'b0, 1'b1, 1'b1, 32'h500, 32'h77);
        wait_ready(1'b0, 8, got);
        chk("rst_ready", got, 1);
        @(posedge ACLK); #1;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge ACLK);
        chk("rst_in_wait_w", dbg_state, 3'd4);
        set_req(1'b0, 1'b1, 1'b0, 32'h600, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 32'h700, 32'h0);
        ARESETN = 1'b0;
        #1;
        chk_all_zero("rst_async");
        late_dones = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge ACLK);
            if (bus.REQ0_DONE || bus.REQ1_DONE) late_dones++;
        end
        chk("rst_no_done", late_dones, 0);
        set_master(0, 1, 1'b0, 32'h9999, 1'b1);
        ARESETN = 1'b1;
        #1;
        chk("rst_rel_ready0", bus.REQ0_READY, 1);
        chk("rst_rel_ready1", bus.REQ1_READY, 0);
        @(posedge ACLK); #1;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        wait_done(1'b0, 20, cyc, rq);
        chk("rst_after_done_cycle", cyc, 2);
        chk("rst_after_rdata", bus.REQ0_RDATA, 32'h9999);
        chk("rst_after_resp", bus.REQ0_RESP, 2'b00);
        repeat (3) @(posedge ACLK);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
